// File: rtl/arb_wrr_lock.sv
// Weighted round-robin arbiter with per-requester burst weights, grant locking and masking.
// Every output is decoded from the owner registers, so no input reaches an output in the same cycle.
module arb_wrr_lock #(
    parameter int N  = 4,
    parameter int WW = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init_n,
    input  logic            enable,
    input  logic [N-1:0]    request,
    input  logic [N-1:0]    mask,
    input  logic [N-1:0]    lock,
    input  logic [N*WW-1:0] weight,
    output logic            granted,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_index
);

    localparam logic [WW-1:0] CNT_MAX = '1;
    localparam logic [IW-1:0] LAST    = IW'(N - 1);

    logic          valid_reg, valid_next;
    logic [IW-1:0] owner_reg, owner_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [WW-1:0] cnt_reg, cnt_next;

    logic [N-1:0]  eff;
    logic [WW-1:0] w_field [N];
    logic [WW-1:0] w_owner;
    logic          hold;
    logic [IW-1:0] start_base, start;
    logic          found;
    logic [IW-1:0] win;

    assign eff = request & ~mask;

    // A programmed weight of zero behaves as a single-cycle burst.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_weight
            assign w_field[gi] = (weight[gi*WW +: WW] == '0) ? WW'(1) : weight[gi*WW +: WW];
        end
    endgenerate

    assign w_owner = w_field[owner_reg];
    assign hold    = valid_reg && eff[owner_reg] && (lock[owner_reg] || (cnt_reg < w_owner));

    // Circular search for the next requester, starting just past the owner or last winner.
    always_comb begin
        start_base = valid_reg ? owner_reg : ptr_reg;
        start      = (start_base == LAST) ? '0 : start_base + IW'(1);
        found      = 1'b0;
        win        = '0;
        for (int k = 0; k < N; k++) begin
            int            idx;
            logic [IW-1:0] sel;
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!found && eff[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    always_comb begin
        valid_next = valid_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        if (!init_n) begin
            valid_next = 1'b0;
            owner_next = '0;
            ptr_next   = LAST;
            cnt_next   = '0;
        end else if (!enable) begin
            valid_next = 1'b0;
            owner_next = '0;
            cnt_next   = '0;
        end else if (hold) begin
            cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + WW'(1);
        end else if (found) begin
            valid_next = 1'b1;
            owner_next = win;
            ptr_next   = win;
            cnt_next   = WW'(1);
        end else begin
            valid_next = 1'b0;
            owner_next = '0;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            owner_reg <= '0;
            ptr_reg   <= LAST;
            cnt_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = valid_reg && (owner_reg == IW'(gi));
        end
    endgenerate

    assign granted     = valid_reg;
    assign grant_index = valid_reg ? owner_reg : '0;

endmodule

// File: tb/tb_arb_wrr_lock.sv
// Scoreboard bench for arb_wrr_lock: directed scenarios plus randomized traffic against a rule-level model.
module tb_arb_wrr_lock;

    localparam int N    = 4;
    localparam int WW   = 3;
    localparam int IW   = 2;
    localparam int CMAX = (1 << WW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init_n = 1'b1;
    logic            enable = 1'b1;
    logic [N-1:0]    request = '0;
    logic [N-1:0]    mask = '0;
    logic [N-1:0]    lock = '0;
    logic [N*WW-1:0] weight = '0;
    logic            granted;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_index;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    typedef struct packed {
        logic          g;
        logic [N-1:0]  gv;
        logic [IW-1:0] idx;
    } exp_t;
    exp_t exp_q[$];

    // Model state: owner, burst length so far, last winner.
    int m_valid = 0;
    int m_o     = 0;
    int m_cnt   = 0;
    int m_p     = N - 1;

    always #5 clk = ~clk;

    arb_wrr_lock #(.N(N), .WW(WW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_n      (init_n),
        .enable      (enable),
        .request     (request),
        .mask        (mask),
        .lock        (lock),
        .weight      (weight),
        .granted     (granted),
        .grant       (grant),
        .grant_index (grant_index)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int wt(input int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    // Applies the arbitration rules for one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [N-1:0] eff;
        int start;
        int found;
        eff = request & ~mask;
        if (!init_n) begin
            m_valid = 0; m_o = 0; m_cnt = 0; m_p = N - 1;
        end else if (!enable) begin
            m_valid = 0; m_cnt = 0;
        end else if (m_valid == 1 && eff[m_o] && (lock[m_o] || m_cnt < wt(m_o))) begin
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else begin
            start = (m_valid == 1) ? m_o + 1 : m_p + 1;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (start + k) % N;
                if (found == 0 && eff[j]) begin
                    found = 1; m_o = j; m_p = j; m_cnt = 1; m_valid = 1;
                end
            end
            if (found == 0) begin
                m_valid = 0; m_cnt = 0;
            end
        end
    endtask

    // One clock: drive (already done by caller), predict, push, optionally check a directed owner.
    // exp_idx: -2 = no directed check, -1 = no grant expected, else expected owner index.
    task automatic step(input int exp_idx);
        exp_t e;
        model_edge();
        e.g   = (m_valid == 1);
        e.gv  = (m_valid == 1) ? N'(1 << m_o) : '0;
        e.idx = (m_valid == 1) ? IW'(m_o) : '0;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        if (exp_idx == -1) begin
            check("dir_granted", 32'(granted), 32'(0));
        end else if (exp_idx >= 0) begin
            check("dir_granted", 32'(granted), 32'(1));
            check("dir_index", 32'(grant_index), 32'(exp_idx));
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_granted", 32'(granted), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_index", 32'(grant_index), 32'(0));
        m_valid = 0; m_o = 0; m_cnt = 0; m_p = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endtask

    // Monitor: one transaction per clock while expectations are queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: grant=%b index=%0d granted=%b", n_txn, grant, grant_index, granted);
                check("grant", 32'(grant), 32'(e.gv));
                check("grant_index", 32'(grant_index), 32'(e.idx));
                check("granted", 32'(granted), 32'(e.g));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq3 [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        #1;
        check("por_granted", 32'(granted), 32'(0));
        check("por_grant", 32'(grant), 32'(0));
        check("por_index", 32'(grant_index), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // First grant and idle
        set_w(1, 1, 1, 1);
        request = 4'b0100; step(2);
        request = 4'b0000; step(-1);

        // Equal weights
        init_n = 1'b0; step(-1); init_n = 1'b1;
        request = 4'b1111;
        step(0); step(1); step(2); step(3); step(0);

        // Weighted shares, then sole requester with w0=2
        init_n = 1'b0; step(-1); init_n = 1'b1;
        set_w(3, 1, 2, 0);
        for (int i = 0; i < 10; i++) step(seq3[i]);
        set_w(2, 1, 1, 1);
        request = 4'b0001;
        for (int i = 0; i < 4; i++) step(0);

        // Lock holds for 20 cycles, release rotates
        init_n = 1'b0; step(-1); init_n = 1'b1;
        set_w(1, 1, 1, 1);
        request = 4'b1111; lock = 4'b0010;
        step(0);
        for (int i = 0; i < 20; i++) step(1);
        lock = 4'b0000; step(2);

        // Counter saturates while locked instead of wrapping
        init_n = 1'b0; step(-1); init_n = 1'b1;
        set_w(7, 7, 7, 7);
        request = 4'b0001; lock = 4'b0001;
        for (int i = 0; i < 12; i++) step(0);
        lock = 4'b0000; request = 4'b0011; step(1);

        // Early release by dropped request, then by mask
        init_n = 1'b0; step(-1); init_n = 1'b1;
        set_w(4, 1, 1, 1);
        request = 4'b0011; step(0); step(0);
        request = 4'b0010; step(1);
        init_n = 1'b0; step(-1); init_n = 1'b1;
        request = 4'b0011; step(0); step(0);
        mask = 4'b0001; step(1);
        mask = 4'b0000;

        // Control priority: enable, init_n, asynchronous reset
        init_n = 1'b0; step(-1); init_n = 1'b1;
        set_w(4, 4, 4, 4);
        request = 4'b1111; step(0); step(0);
        enable = 1'b0; step(-1);
        enable = 1'b1; step(1); step(1);
        init_n = 1'b0; enable = 1'b0; step(-1);
        init_n = 1'b1; enable = 1'b1; step(0); step(0);
        request = 4'b0110;
        pulse_reset();
        step(1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            request = N'($urandom);
            mask    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            lock    = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) weight = (N*WW)'($urandom);
            enable  = ($urandom_range(0, 9) != 0);
            init_n  = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step(-2);
        end

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb_wrr_lock.md
Name: arb_wrr_lock

Overview:
Parametrised weighted round-robin arbiter with per-requester burst weights, grant locking and request masking. It is the next generation of the team's round-robin arbiter. Each winner may hold the grant for up to its programmed weight in consecutive cycles, or indefinitely while locked, before priority rotates. It sits in front of shared buses and memory ports where bandwidth shares per requester must be set at run time.

Parameters:
N, 4, number of requesters; legal range 2..32.
WW, 3, bit width of each per-requester weight field; legal range 1..8.
IW, derived, index width = ceil(log2(N)); local, not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
init_n  input  1  synchronous active-low state initialise.
enable  input  1  arbitration enable; 0 = no grants.
request  input  N  request vector, bit i = requester i.
mask  input  N  1 = requester ignored.
lock  input  N  1 = requester keeps the grant once it owns it.
weight  input  N*WW  weight of requester i in bits [i*WW +: WW]; value 0 is treated as 1.
granted  output  1  some grant is active.
grant  output  N  one-hot grant, or all zero.
grant_index  output  IW  index of the owner; 0 when granted=0.

Behaviour:
- State registers: owner valid flag, owner index o, burst count cnt (WW bits, saturating at 2^WW-1), last-winner pointer p. All outputs are decoded directly from registers; there is no combinational input-to-output path.
- Latency: inputs are sampled at edge k. The resulting grant is visible after edge k and is stable for cycle k+1.
- Reset (rst_n=0, asynchronous): granted=0, grant=0, grant_index=0, valid=0, cnt=0, p=N-1, so the first search starts at index 0.
- init_n=0 at an edge: same values as reset, applied synchronously. init_n overrides enable.
- enable=0 at an edge (with init_n=1): valid=0, cnt=0, outputs go to 0, p is held.
- Effective request: eff = request & ~mask. w_i = weight field i, or 1 if the field is 0. The weight field is read live every cycle.
- Per edge, with enable=1 and init_n=1:
  - Hold: if valid, eff[o]=1, and either lock[o]=1 or cnt < w_o, then the owner is kept and cnt increments (saturating).
  - Rotate: otherwise, search eff starting at (o+1) mod N when valid, else at (p+1) mod N, wrapping once. The first set bit j wins: o=j, p=j, cnt=1, valid=1.
  - Idle: if no bit is found, valid=0, cnt=0, p is unchanged.
- Sole requester: when its burst is exhausted, the wrapped search re-grants it with cnt=1. The grant stays continuous with no idle cycle.
- Owner drops its request, or becomes masked, mid-burst: the Rotate rule applies at that same edge. There is no dead cycle when another requester is pending.
- Lock asserted while not owner: no effect until the requester wins normally. lock deasserted while owner: the weight check resumes with the current cnt. If cnt >= w_o, the grant rotates at the next edge.
- Saturation: a locked owner's cnt saturates at 2^WW-1 and does not wrap.
- Reset during a burst: all outputs clear asynchronously. After release, the first winner is the lowest-index effective requester.
- Invariants: grant is always one-hot or zero. granted equals OR(grant). grant_index matches grant.

Test Plan:
1. Reset and first grant: rst_n=0 -> all outputs 0 immediately. Release; request=0100, weights all 1 -> grant=0100, grant_index=2, granted=1 one cycle later. Request=0 -> granted=0 next cycle.
2. Equal weights: all weights 1, request=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
3. Weighted shares: weights w0=3, w1=1, w2=2, w3=0, request=1111 held -> owner indices 0,0,0,1,2,2,3,0,0,0 on consecutive cycles. Sole requester 0 with w0=2 -> continuous grant=0001, with cnt cycling 1,2,1,2.
4. Lock: w1=1, request=1111, lock=0010 -> grant=0010 for 20 consecutive cycles. Drop lock -> next cycle grant=0100.
5. Early release and mask: w0=4, request=0011, owner 0 at cnt=2; drop request[0] -> next cycle grant=0010. Repeat, setting mask=0001 instead -> same response.
6. Control priority: mid-burst enable=0 -> grant=0 next cycle; re-enable -> search resumes from p+1. Mid-burst init_n=0 with enable=0 -> reset values. Mid-burst rst_n pulse -> immediate clear; first winner afterwards is the lowest-index requester.
